// File: rtl/pipe_stage_skid_reg.sv
// Inter-stage pipeline register with valid/ready handshake and a 2-entry skid buffer.
// Invalid entries are zeroed so bubbles never assert control; idle cycles are counted.
`timescale 1ns/1ps
module pipe_stage_skid_reg #(
  parameter int CTRL_W = 8,
  parameter int DATA_W = 128,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]  bubble_cnt
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_t              state_r, state_s;
  logic                main_valid_r;
  logic                in_ready_r;
  logic [CTRL_W-1:0]   main_ctrl_r, skid_ctrl_r;
  logic [DATA_W-1:0]   main_data_r, skid_data_r;
  logic [CNT_W-1:0]    bubble_cnt_r;
  logic                acc_s, dq_s;
  logic                load_main_in_s, load_main_skid_s, load_skid_s, clear_main_s;

  assign acc_s = in_valid & in_ready_r;
  assign dq_s  = main_valid_r & out_ready;

  // Next-state and storage-steering decode; flush dominates any handshake.
  always_comb begin
    state_s          = state_r;
    load_main_in_s   = 1'b0;
    load_main_skid_s = 1'b0;
    load_skid_s      = 1'b0;
    clear_main_s     = 1'b0;
    if (flush) begin
      state_s      = ST_EMPTY;
      clear_main_s = 1'b1;
    end else begin
      case (state_r)
        ST_EMPTY: begin
          if (acc_s) begin
            state_s        = ST_ONE;
            load_main_in_s = 1'b1;
          end else begin
            state_s = ST_EMPTY;
          end
        end
        ST_ONE: begin
          if (acc_s && dq_s) begin
            load_main_in_s = 1'b1;
          end else if (acc_s) begin
            state_s     = ST_FULL;
            load_skid_s = 1'b1;
          end else if (dq_s) begin
            state_s      = ST_EMPTY;
            clear_main_s = 1'b1;
          end else begin
            state_s = ST_ONE;
          end
        end
        ST_FULL: begin
          if (dq_s) begin
            state_s          = ST_ONE;
            load_main_skid_s = 1'b1;
          end else begin
            state_s = ST_FULL;
          end
        end
        default: begin
          state_s      = ST_EMPTY;
          clear_main_s = 1'b1;
        end
      endcase
    end
  end

  // State register plus registered valid/ready flags derived from the next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= ST_EMPTY;
      main_valid_r <= 1'b0;
      in_ready_r   <= 1'b1;
    end else begin
      state_r      <= state_s;
      main_valid_r <= (state_s != ST_EMPTY);
      in_ready_r   <= (state_s != ST_FULL);
    end
  end

  // Main entry; cleared whenever it goes invalid so outputs are zero during bubbles.
  always_ff @(posedge clk) begin
    if (rst) begin
      main_ctrl_r <= '0;
      main_data_r <= '0;
    end else if (load_main_in_s) begin
      main_ctrl_r <= in_ctrl;
      main_data_r <= in_data;
    end else if (load_main_skid_s) begin
      main_ctrl_r <= skid_ctrl_r;
      main_data_r <= skid_data_r;
    end else if (clear_main_s) begin
      main_ctrl_r <= '0;
      main_data_r <= '0;
    end else begin
      main_ctrl_r <= main_ctrl_r;
      main_data_r <= main_data_r;
    end
  end

  // Skid entry absorbs the one beat accepted while downstream stalls.
  always_ff @(posedge clk) begin
    if (rst) begin
      skid_ctrl_r <= '0;
      skid_data_r <= '0;
    end else if (load_skid_s) begin
      skid_ctrl_r <= in_ctrl;
      skid_data_r <= in_data;
    end else begin
      skid_ctrl_r <= skid_ctrl_r;
      skid_data_r <= skid_data_r;
    end
  end

  // Saturating count of cycles presenting a bubble downstream.
  always_ff @(posedge clk) begin
    if (rst) begin
      bubble_cnt_r <= '0;
    end else if (!main_valid_r && (bubble_cnt_r != CNT_MAX)) begin
      bubble_cnt_r <= bubble_cnt_r + CNT_ONE;
    end else begin
      bubble_cnt_r <= bubble_cnt_r;
    end
  end

  assign in_ready   = in_ready_r;
  assign out_valid  = main_valid_r;
  assign out_ctrl   = main_ctrl_r;
  assign out_data   = main_data_r;
  assign bubble_cnt = bubble_cnt_r;

endmodule
